mesm6_membus_arbiter: RTL and testbench

- Shares one single-ported 48-bit main-memory interface between the MESM-6 core's instruction bus (ibus) and data bus (dbus).
- Sits between mesm6_core and the memory/peripheral fabric; presents core-facing ports identical in meaning to the core's bus ports.
- Adds a registered request/acknowledge sequencer, fixed data-over-instruction priority and an acknowledge watchdog.

---
 rtl/mesm6_bus_pkg.sv | 23 ++
 rtl/mesm6_ifetch_buf.sv | 42 ++++
 rtl/mesm6_membus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mesm6_membus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_bus_pkg.sv
// Shared types and defaults for the MESM-6 instruction/data memory bus arbiter.
// Used by mesm6_membus_arbiter and mesm6_ifetch_buf.
package mesm6_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DBUS,
        IBUS,
        DONE
    } bus_state_t;

    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_DATA_W      = 48;
    localparam int DEF_ACK_TIMEOUT = 255;

    // A disabled watchdog still gets a 1-bit counter so the logic stays legal.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEF_WD_W = wd_width(DEF_ACK_TIMEOUT);

endpackage

// File: rtl/mesm6_ifetch_buf.sv
// One-entry instruction fetch buffer for mesm6_membus_arbiter.
// Only instantiated when MESM6_IFETCH_BUF_EN is defined.
module mesm6_ifetch_buf
    import mesm6_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] inval_addr
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            addr_q  <= load_addr;
            data_q  <= load_data;
        end else if (inval && inval_addr == addr_q) begin
            valid_q <= 1'b0;
        end
    end

    assign hit      = valid_q && (lookup_addr == addr_q);
    assign hit_data = data_q;

endmodule

// File: rtl/mesm6_membus_arbiter.sv
// Shares one memory port between MESM-6 ibus and dbus, dbus first, with ack watchdog.
// Optional one-entry fetch buffer enabled by defining MESM6_IFETCH_BUF_EN.
module mesm6_membus_arbiter
    import mesm6_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_output,
    output logic [DATA_W-1:0] dbus_input,
    output logic              dbus_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_error
);

    localparam int              WD_W     = wd_width(ACK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(ACK_TIMEOUT);

    bus_state_t        state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, ibus_input_d, dbus_input_d;
    logic              ibus_done_d, dbus_done_d, bus_error_d;
    logic              wd_expire, finish, grant_hit, from_buf;
    logic [DATA_W-1:0] fin_data, buf_data;

    assign wd_inc    = wd_q + WD_W'(1);
    assign wd_expire = (ACK_TIMEOUT != 0) && mem_req && !mem_ack
                       && (wd_inc == WD_LIMIT);
    assign finish    = from_buf || (mem_req && (mem_ack || wd_expire));
    // Ack beats a simultaneous expiry; a bare expiry returns zero.
    assign fin_data  = from_buf ? buf_data :
                       (mem_ack ? mem_rdata : '0);

`ifdef MESM6_IFETCH_BUF_EN
    logic              buf_hit, buf_pend_q, buf_load, buf_inval;
    logic [ADDR_W-1:0] buf_lookup;

    assign buf_lookup = (state_q == IDLE) ? ibus_addr : mem_addr;
    assign buf_load   = (state_q == IBUS) && mem_req && mem_ack;
    assign buf_inval  = (state_q == DBUS) && mem_we && finish;

    mesm6_ifetch_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ifetch_buf (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(buf_lookup),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .load       (buf_load),
        .load_addr  (mem_addr),
        .load_data  (mem_rdata),
        .inval      (buf_inval),
        .inval_addr (mem_addr)
    );

    always_ff @(posedge clk) begin
        if (reset)
            buf_pend_q <= 1'b0;
        else
            buf_pend_q <= (state_q == IDLE) && !(dbus_read || dbus_write)
                          && ibus_fetch && buf_hit;
    end

    assign grant_hit = buf_hit;
    assign from_buf  = buf_pend_q;
`else
    assign grant_hit = 1'b0;
    assign from_buf  = 1'b0;
    assign buf_data  = '0;
`endif

    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        ibus_input_d = ibus_input;
        dbus_input_d = dbus_input;
        ibus_done_d  = 1'b0;
        dbus_done_d  = 1'b0;
        bus_error_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dbus_read || dbus_write) begin
                    state_d     = DBUS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dbus_write;
                    mem_addr_d  = dbus_addr;
                    mem_wdata_d = dbus_output;
                    wd_d        = '0;
                end else if (ibus_fetch) begin
                    state_d    = IBUS;
                    mem_req_d  = !grant_hit;
                    mem_we_d   = 1'b0;
                    mem_addr_d = ibus_addr;
                    wd_d       = '0;
                end
            end
            DBUS, IBUS: begin
                if (finish) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    bus_error_d = !from_buf && !mem_ack;
                    if (state_q == DBUS) begin
                        dbus_done_d = 1'b1;
                        if (!mem_we)
                            dbus_input_d = fin_data;
                    end else begin
                        ibus_done_d  = 1'b1;
                        ibus_input_d = fin_data;
                    end
                end else if (mem_req) begin
                    wd_d = wd_inc;
                end
            end
            // Core still holds the completed request here.
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ibus_input <= '0;
            dbus_input <= '0;
            ibus_done  <= 1'b0;
            dbus_done  <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            ibus_input <= ibus_input_d;
            dbus_input <= dbus_input_d;
            ibus_done  <= ibus_done_d;
            dbus_done  <= dbus_done_d;
            bus_error  <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_mesm6_membus_arbiter.sv
// Self-checking bench for mesm6_membus_arbiter (ACK_TIMEOUT = 4).
// Buffer checks are active when MESM6_IFETCH_BUF_EN is defined.
module tb_mesm6_membus_arbiter;

    localparam int AW = 15;
    localparam int DW = 48;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ibus_fetch, ibus_done;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_input;
    logic          dbus_read, dbus_write, dbus_done;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_output, dbus_input;
    logic          mem_req, mem_we, mem_ack, bus_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mesm6_membus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ibus_fetch (ibus_fetch),
        .ibus_addr  (ibus_addr),
        .ibus_input (ibus_input),
        .ibus_done  (ibus_done),
        .dbus_read  (dbus_read),
        .dbus_write (dbus_write),
        .dbus_addr  (dbus_addr),
        .dbus_output(dbus_output),
        .dbus_input (dbus_input),
        .dbus_done  (dbus_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .bus_error  (bus_error)
    );

    typedef struct {
        logic          fetch;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            delay;
        int            exp_nreq;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    logic          hold_fetch = 1'b0;
    logic [AW-1:0] hold_faddr = '0;

    // Transaction-level model: last data per bus plus buffer contents.
    logic [DW-1:0] m_d = '0, m_i = '0, m_bd = '0;
    logic [AW-1:0] m_ba = '0;
    logic          m_bv = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic rd, input logic wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rdat, input int dly);
        vec_t v;
        logic hit;
        logic bus_d;
        v.fetch = f; v.rd = rd; v.wr = wr; v.addr = a;
        v.wdata = wd; v.rdata = rdat; v.delay = dly;
        bus_d = rd | wr;
        hit = 1'b0;
`ifdef MESM6_IFETCH_BUF_EN
        hit = !bus_d && m_bv && (m_ba == a);
`endif
        if (hit) begin
            v.exp_nreq = 0;
            v.exp_lat  = 2;
            v.exp_err  = 1'b0;
            v.exp_data = m_bd;
        end else begin
            v.exp_nreq = (dly > TO) ? TO : dly;
            v.exp_lat  = v.exp_nreq + 1;
            v.exp_err  = dly > TO;
            if (bus_d && wr)
                v.exp_data = m_d;
            else
                v.exp_data = v.exp_err ? '0 : rdat;
        end
        return v;
    endfunction

    task automatic model_update(input vec_t v);
        if (v.rd || v.wr) begin
            if (!v.wr)
                m_d = v.exp_data;
            if (v.wr && m_ba == v.addr)
                m_bv = 1'b0;
        end else begin
            m_i = v.exp_data;
            if (v.exp_nreq > 0 && !v.exp_err) begin
                m_bv = 1'b1;
                m_ba = v.addr;
                m_bd = v.exp_data;
            end
        end
    endtask

    // Starts at an idle negedge; returns at the negedge where done is seen,
    // with the request still held as a registered core would.
    task automatic run_txn(input vec_t v);
        int   reqcnt;
        int   lat;
        bit   bad_mem;
        bit   seen;
        logic is_d;
        logic [DW-1:0] act;
        is_d = v.rd | v.wr;
        @(negedge clk);
        check(!mem_req && !ibus_done && !dbus_done && !bus_error, "idle_quiet",
              64'({mem_req, ibus_done, dbus_done, bus_error}), 64'(0));
        ibus_fetch  = v.fetch | hold_fetch;
        ibus_addr   = v.fetch ? v.addr : hold_faddr;
        dbus_read   = v.rd;
        dbus_write  = v.wr;
        dbus_addr   = v.addr;
        dbus_output = v.wdata;
        reqcnt = 0; lat = 0; bad_mem = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = DW'({$urandom(), $urandom()});
            if (ibus_done || dbus_done) begin
                seen = 1;
                lat  = i;
            end else if (mem_req) begin
                reqcnt++;
                if (mem_addr != v.addr || mem_we != v.wr
                    || (v.wr && mem_wdata != v.wdata))
                    bad_mem = 1;
                if (reqcnt == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
        end
        if (!seen) begin
            check(0, "done_timeout", 64'(reqcnt), 64'(v.exp_nreq));
            return;
        end
        check(reqcnt == v.exp_nreq, "req_cycles", 64'(reqcnt), 64'(v.exp_nreq));
        check(lat == v.exp_lat, "latency", 64'(lat), 64'(v.exp_lat));
        check(!bad_mem, "mem_fields", 64'(mem_addr), 64'(v.addr));
        check(dbus_done == is_d && ibus_done == !is_d, "done_bus",
              64'({dbus_done, ibus_done}), 64'({is_d, !is_d}));
        check(bus_error == v.exp_err, "bus_error", 64'(bus_error), 64'(v.exp_err));
        act = is_d ? dbus_input : ibus_input;
        check(act == v.exp_data, "rdata", 64'(act), 64'(v.exp_data));
    endtask

    vec_t tbl[8];
    vec_t v;

    function automatic vec_t tv(input logic f, input logic rd, input logic wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rdat, input int dly,
                                input int nreq, input int lat, input logic err,
                                input logic [DW-1:0] dat);
        vec_t r;
        r.fetch = f; r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
        r.rdata = rdat; r.delay = dly; r.exp_nreq = nreq; r.exp_lat = lat;
        r.exp_err = err; r.exp_data = dat;
        return r;
    endfunction

    initial begin
        tbl[0] = tv(0, 1, 0, 15'o1234, '0, 48'h123456789ABC, 3, 3, 4, 0, 48'h123456789ABC);
        tbl[1] = tv(0, 0, 1, 15'o200, 48'h00000000FFFF, '0, 1, 1, 2, 0, 48'h123456789ABC);
        tbl[2] = tv(1, 0, 0, 15'o101, '0, 48'hA5A500001111, 2, 2, 3, 0, 48'hA5A500001111);
        tbl[3] = tv(0, 1, 0, 15'o400, '0, 48'h000000000001, 9, 4, 5, 1, 48'h0);
        tbl[4] = tv(0, 1, 0, 15'o401, '0, 48'h0000DEADBEEF, 4, 4, 5, 0, 48'h0000DEADBEEF);
        tbl[5] = tv(1, 0, 0, 15'o77, '0, 48'h000000000002, 7, 4, 5, 1, 48'h0);
        tbl[6] = tv(0, 1, 1, 15'o7777, 48'h000000005555, 48'h3, 1, 1, 2, 0, 48'h0000DEADBEEF);
        tbl[7] = tv(1, 0, 0, 15'o102, '0, 48'hFFFFFFFFFFFF, 1, 1, 2, 0, 48'hFFFFFFFFFFFF);

        reset = 1'b1; ibus_fetch = 0; ibus_addr = '0; dbus_read = 0;
        dbus_write = 0; dbus_addr = '0; dbus_output = '0;
        mem_ack = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check(!mem_req && !mem_we && !bus_error, "rst_ctrl",
              64'({mem_req, mem_we, bus_error}), 64'(0));
        check(!ibus_done && !dbus_done, "rst_done", 64'({ibus_done, dbus_done}), 64'(0));
        check(mem_addr == '0 && mem_wdata == '0, "rst_mem",
              64'(mem_wdata), 64'(0));
        check(ibus_input == '0 && dbus_input == '0, "rst_data",
              64'(ibus_input | dbus_input), 64'(0));

        // Simultaneous fetch and write: write must go first.
        hold_fetch = 1'b1;
        hold_faddr = 15'o100;
        v = mk(0, 0, 1, 15'o200, 48'h00000000FFFF, '0, 1);
        run_txn(v); model_update(v);
        hold_fetch = 1'b0;
        v = mk(1, 0, 0, 15'o100, '0, 48'h0BADCAFE0100, 1);
        run_txn(v); model_update(v);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            model_update(tbl[i]);
        end

        // Back-to-back reads with no idle gap from the core.
        v = mk(0, 1, 0, 15'o300, '0, 48'h111122223333, 2);
        run_txn(v); model_update(v);
        v = mk(0, 1, 0, 15'o301, '0, 48'h444455556666, 1);
        run_txn(v); model_update(v);

`ifdef MESM6_IFETCH_BUF_EN
        v = mk(1, 0, 0, 15'o50, '0, 48'h505050505050, 1);
        run_txn(v); model_update(v);
        v = mk(1, 0, 0, 15'o50, '0, 48'h0, 1);
        run_txn(v); model_update(v);
        v = mk(0, 0, 1, 15'o50, 48'h000000000777, '0, 2);
        run_txn(v); model_update(v);
        v = mk(1, 0, 0, 15'o50, '0, 48'h0000ABCD0050, 1);
        run_txn(v); model_update(v);
`endif

        for (int n = 0; n < 40; n++) begin
            int            kind;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            kind = $urandom_range(0, 3);
            a    = AW'(15'o40 + $urandom_range(0, 7));
            wd   = DW'({$urandom(), $urandom()});
            rd   = DW'({$urandom(), $urandom()});
            v = mk(kind == 0, kind == 1 || kind == 3, kind >= 2, a, wd, rd,
                   $urandom_range(1, 6));
            run_txn(v); model_update(v);
        end

        // Reset while mem_req is high, then a late ack.
        @(negedge clk);
        ibus_fetch = 0; dbus_read = 1; dbus_write = 0; dbus_addr = 15'o321;
        @(negedge clk);
        check(mem_req, "rst_pre_req", 64'(mem_req), 64'(1));
        reset = 1'b1;
        dbus_read = 0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 48'h000000000777;
        @(negedge clk);
        mem_ack = 1'b0;
        check(dbus_input == '0 && ibus_input == '0, "rst_mid_data",
              64'(dbus_input | ibus_input), 64'(0));
        for (int k = 0; k < 3; k++) begin
            check(!mem_req && !dbus_done && !ibus_done && !bus_error, "rst_mid_quiet",
                  64'({mem_req, dbus_done, ibus_done, bus_error}), 64'(0));
            if (k < 2) @(negedge clk);
        end
        m_d = '0; m_i = '0; m_bv = 1'b0;
        v = mk(0, 1, 0, 15'o5, '0, 48'h00000000CAFE, 1);
        run_txn(v); model_update(v);

        @(negedge clk);
        ibus_fetch = 0; dbus_read = 0; dbus_write = 0;
        repeat (2) @(negedge clk);
        check(!mem_req && !dbus_done && !ibus_done, "end_quiet",
              64'({mem_req, dbus_done, ibus_done}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
